// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_fetch_pkg;

  localparam int unsigned INSTR_W             = 32;
  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned LANE_W              = $clog2(BYTES_PER_WORD);
  localparam logic [INSTR_W-1:0] RESET_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fetch_state_e;

  typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Lane-indexed 4x8 capture register; presents the little-endian word {b3,b2,b1,b0}.
module fetch_byte_assembler
  import cpu_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  lane_t              load_lane,
  input  logic [7:0]         load_data,
  output logic [INSTR_W-1:0] word
);

  logic [BYTES_PER_WORD-1:0][7:0] lanes_q;
  logic [BYTES_PER_WORD-1:0][7:0] lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (load_en) begin
      lanes_d[load_lane] = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  // Word already includes the byte being captured this cycle, so the
  // controller can latch the full instruction on the final-lane edge.
  assign word = lanes_d;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Byte-serial instruction fetch sequencer with a one-entry fetch buffer.
module instr_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned      ADDR_WIDTH  = 10,
  parameter logic [31:0]      RESET_INSTR = RESET_INSTR_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  input  logic                  FETCH,
  input  logic                  FLUSH,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  FETCH_ERR,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [7:0]            MEM_RDATA
);

  localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  lane_t                 cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_read_q, mem_read_d;
  logic [31:0]           instr_q, instr_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic                  fetch_err_q, fetch_err_d;
  logic                  flush_pend_q, flush_pend_d;

  logic                  hit;
  logic                  err;
  logic [INSTR_W-1:0]    asm_word;

  assign hit = buf_valid_q & (PC == 32'(buf_addr_q));
  assign err = (PC[1:0] != 2'b00) | ((PC >> ADDR_WIDTH) != 32'd0);

  fetch_byte_assembler u_asm (
    .clk       (CLK),
    .rst       (RESET),
    .load_en   (state_q == READ),
    .load_lane (cnt_q),
    .load_data (MEM_RDATA),
    .word      (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = mem_read_q;
    instr_d      = instr_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    fetch_err_d  = 1'b0;
    flush_pend_d = flush_pend_q;

    unique case (state_q)
      IDLE: begin
        if (FLUSH) begin
          buf_valid_d = 1'b0;
          instr_d     = RESET_INSTR;
        end
        if (FETCH && err) begin
          fetch_err_d = 1'b1;
        end else if (FETCH && !hit) begin
          base_d       = PC[ADDR_WIDTH-1:0];
          cnt_d        = '0;
          mem_addr_d   = PC[ADDR_WIDTH-1:0];
          mem_read_d   = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = READ;
        end
      end
      READ: begin
        if (FLUSH) begin
          flush_pend_d = 1'b1;
        end
        if (cnt_q == LAST_LANE) begin
          // A flush seen at any point of the fetch still delivers the word
          // but leaves the buffer invalid, so the next request refetches.
          instr_d      = asm_word;
          buf_addr_d   = base_q;
          buf_valid_d  = ~(flush_pend_q | FLUSH);
          mem_read_d   = 1'b0;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end else begin
          cnt_d      = cnt_q + lane_t'(1);
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      instr_q      <= RESET_INSTR;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      fetch_err_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      instr_q      <= instr_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      fetch_err_q  <= fetch_err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign BUSYWAIT    = (state_q != IDLE) | (FETCH & ~hit & ~err);
  assign INSTRUCTION = instr_q;
  assign FETCH_ERR   = fetch_err_q;
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDR    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural byte-wide instruction memory.
module tb_instr_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic        FETCH;
  logic        FLUSH;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        FETCH_ERR;
  logic        MEM_READ;
  logic [9:0]  MEM_ADDR;
  logic [7:0]  MEM_RDATA;

  logic [7:0]  mem [0:1023];
  int          vectors    = 0;
  int          miscompares = 0;

  assign MEM_RDATA = mem[MEM_ADDR];

  always #5 CLK = ~CLK;

  instr_fetch_ctrl #(
    .ADDR_WIDTH  (10),
    .RESET_INSTR (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .FETCH       (FETCH),
    .FLUSH       (FLUSH),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .FETCH_ERR   (FETCH_ERR),
    .MEM_READ    (MEM_READ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_RDATA   (MEM_RDATA)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  task automatic test_reset();
    RESET = 1'b1; FETCH = 1'b0; FLUSH = 1'b0; PC = 32'd0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR} !== {32'h0, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got instr=%h busy=%b err=%b rd=%b addr=%0d required 00000000/0/0/0/0",
               INSTRUCTION, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR);
    end
  endtask

  task automatic test_miss_basic();
    @(negedge CLK);
    FETCH = 1'b1; PC = 32'd0;
    #1;
    vectors++;
    if ({BUSYWAIT, MEM_READ} !== 2'b10) begin
      miscompares++;
      $display("FAIL miss_c0: got busy=%b rd=%b required busy=1 rd=0", BUSYWAIT, MEM_READ);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      vectors++;
      if ({BUSYWAIT, MEM_READ, MEM_ADDR} !== {1'b1, 1'b1, 10'(k)}) begin
        miscompares++;
        $display("FAIL miss_read_c%0d: got busy=%b rd=%b addr=%0d required 1/1/%0d",
                 k + 1, BUSYWAIT, MEM_READ, MEM_ADDR, k);
      end
    end
    @(negedge CLK); #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT, MEM_READ} !== {32'h0000_0003, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL miss_c5: got instr=%h busy=%b rd=%b required 00000003/0/0", INSTRUCTION, BUSYWAIT, MEM_READ);
    end
  endtask

  task automatic test_hit();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      FETCH = 1'b1; PC = 32'd0;
      #1;
      vectors++;
      if ({INSTRUCTION, BUSYWAIT, MEM_READ} !== {32'h0000_0003, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL hit_%0d: got instr=%h busy=%b rd=%b required 00000003/0/0", k, INSTRUCTION, BUSYWAIT, MEM_READ);
      end
    end
    FETCH = 1'b0;
  endtask

  task automatic test_pc_change();
    @(negedge CLK);
    FETCH = 1'b1; PC = 32'd8;
    #1;
    vectors++;
    if (BUSYWAIT !== 1'b1) begin
      miscompares++;
      $display("FAIL pcchg_c0: got busy=%b required 1", BUSYWAIT);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 1) PC = 32'd12;
      #1;
      vectors++;
      if ({BUSYWAIT, MEM_READ, MEM_ADDR} !== {1'b1, 1'b1, 10'(8 + k)}) begin
        miscompares++;
        $display("FAIL pcchg_read_c%0d: got busy=%b rd=%b addr=%0d required 1/1/%0d",
                 k + 1, BUSYWAIT, MEM_READ, MEM_ADDR, 8 + k);
      end
    end
    @(negedge CLK); #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT, MEM_READ} !== {32'h0202_0100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pcchg_done: got instr=%h busy=%b rd=%b required 02020100/1/0", INSTRUCTION, BUSYWAIT, MEM_READ);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      vectors++;
      if ({BUSYWAIT, MEM_READ, MEM_ADDR} !== {1'b1, 1'b1, 10'(12 + k)}) begin
        miscompares++;
        $display("FAIL pcchg_refetch_c%0d: got busy=%b rd=%b addr=%0d required 1/1/%0d",
                 k + 1, BUSYWAIT, MEM_READ, MEM_ADDR, 12 + k);
      end
    end
    @(negedge CLK); #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0F0E_0D0C, 1'b0}) begin
      miscompares++;
      $display("FAIL pcchg_second_word: got instr=%h busy=%b required 0f0e0d0c/0", INSTRUCTION, BUSYWAIT);
    end
    FETCH = 1'b0;
  endtask

  task automatic test_error();
    logic [31:0] bad_pc [3];
    logic        err_exp [3];
    bad_pc[0] = 32'd6;      err_exp[0] = 1'b0;
    bad_pc[1] = 32'h400;    err_exp[1] = 1'b1;
    bad_pc[2] = 32'd0;      err_exp[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      FETCH = (k < 2); PC = bad_pc[k];
      #1;
      vectors++;
      if ({FETCH_ERR, BUSYWAIT, MEM_READ, INSTRUCTION} !== {err_exp[k], 1'b0, 1'b0, 32'h0F0E_0D0C}) begin
        miscompares++;
        $display("FAIL err_%0d: got ferr=%b busy=%b rd=%b instr=%h required %b/0/0/0f0e0d0c",
                 k, FETCH_ERR, BUSYWAIT, MEM_READ, INSTRUCTION, err_exp[k]);
      end
    end
    @(negedge CLK); #1;
    vectors++;
    if (FETCH_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_end: got ferr=%b required 0", FETCH_ERR);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge CLK);
    FETCH = 1'b1; PC = 32'd0;
    repeat (5) @(negedge CLK);
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0000_0003, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_prefetch: got instr=%h busy=%b required 00000003/0", INSTRUCTION, BUSYWAIT);
    end
    @(negedge CLK);
    FLUSH = 1'b1;
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0000_0003, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_cycle: got instr=%h busy=%b required 00000003/0", INSTRUCTION, BUSYWAIT);
    end
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT, MEM_READ} !== {32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_after: got instr=%h busy=%b rd=%b required 00000000/1/0", INSTRUCTION, BUSYWAIT, MEM_READ);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      vectors++;
      if ({BUSYWAIT, MEM_READ, MEM_ADDR} !== {1'b1, 1'b1, 10'(k)}) begin
        miscompares++;
        $display("FAIL flush_refetch_c%0d: got busy=%b rd=%b addr=%0d required 1/1/%0d",
                 k + 1, BUSYWAIT, MEM_READ, MEM_ADDR, k);
      end
    end
    @(negedge CLK); #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0000_0003, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_refetch_done: got instr=%h busy=%b required 00000003/0", INSTRUCTION, BUSYWAIT);
    end
  endtask

  task automatic test_flush_read();
    @(negedge CLK);
    FETCH = 1'b1; PC = 32'd8;
    @(negedge CLK);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT, MEM_READ} !== {32'h0202_0100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL flushrd_done: got instr=%h busy=%b rd=%b required 02020100/1/0", INSTRUCTION, BUSYWAIT, MEM_READ);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({MEM_READ, MEM_ADDR} !== {1'b1, 10'd8}) begin
      miscompares++;
      $display("FAIL flushrd_refetch: got rd=%b addr=%0d required 1/8", MEM_READ, MEM_ADDR);
    end
    repeat (4) @(negedge CLK);
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0202_0100, 1'b0}) begin
      miscompares++;
      $display("FAIL flushrd_final: got instr=%h busy=%b required 02020100/0", INSTRUCTION, BUSYWAIT);
    end
    FETCH = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK);
    FETCH = 1'b1; PC = 32'd4;
    @(negedge CLK); #1;
    vectors++;
    if ({MEM_READ, MEM_ADDR} !== {1'b1, 10'd4}) begin
      miscompares++;
      $display("FAIL rstrd_c1: got rd=%b addr=%0d required 1/4", MEM_READ, MEM_ADDR);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; FETCH = 1'b1; PC = 32'd8;
    #1;
    vectors++;
    if ({INSTRUCTION, MEM_READ, MEM_ADDR, BUSYWAIT} !== {32'h0, 1'b0, 10'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rstrd_after: got instr=%h rd=%b addr=%0d busy=%b required 00000000/0/0/1",
               INSTRUCTION, MEM_READ, MEM_ADDR, BUSYWAIT);
    end
    repeat (5) @(negedge CLK);
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0202_0100, 1'b0}) begin
      miscompares++;
      $display("FAIL rstrd_fetch8: got instr=%h busy=%b required 02020100/0", INSTRUCTION, BUSYWAIT);
    end
    @(negedge CLK);
    PC = 32'd4;
    repeat (5) @(negedge CLK);
    #1;
    vectors++;
    if ({INSTRUCTION, BUSYWAIT} !== {32'h0001_0005, 1'b0}) begin
      miscompares++;
      $display("FAIL rstrd_fetch4: got instr=%h busy=%b required 00010005/0", INSTRUCTION, BUSYWAIT);
    end
    FETCH = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    mem[0]  = 8'h03; mem[1]  = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h00;
    mem[4]  = 8'h05; mem[5]  = 8'h00; mem[6]  = 8'h01; mem[7]  = 8'h00;
    mem[8]  = 8'h00; mem[9]  = 8'h01; mem[10] = 8'h02; mem[11] = 8'h02;
    mem[12] = 8'h0C; mem[13] = 8'h0D; mem[14] = 8'h0E; mem[15] = 8'h0F;

    test_reset();
    test_miss_basic();
    test_hit();
    test_pc_change();
    test_error();
    test_flush_idle();
    test_flush_read();
    test_reset_mid_read();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences instruction fetch for the cpu core from the byte-wide instruction memory (8-bit x 1024, little-endian words).
- Accepts a fetch request for PC and reads four consecutive bytes, one per cycle.
- Assembles the bytes into a 32-bit INSTRUCTION and stalls the core through BUSYWAIT until the word is ready.
- Holds a one-entry fetch buffer (last word plus its address) so a repeated fetch of the same PC completes with zero wait.

Parameters:
ADDR_WIDTH, 10, byte-address width of instruction memory (1024 bytes)
RESET_INSTR, 32'h0000_0000, value driven on INSTRUCTION after reset or flush

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
PC  in  32  byte address of requested instruction, from cpu
FETCH  in  1  cpu requests the instruction at PC this cycle
FLUSH  in  1  invalidate fetch buffer (memory reloaded)
INSTRUCTION  out  32  assembled instruction word, {b3,b2,b1,b0}
BUSYWAIT  out  1  cpu must stall; combinational
FETCH_ERR  out  1  one-cycle pulse: misaligned or out-of-range PC
MEM_READ  out  1  byte read strobe to instruction memory
MEM_ADDR  out  ADDR_WIDTH  byte address to instruction memory
MEM_RDATA  in  8  byte read data, valid in the same cycle MEM_ADDR is driven (asynchronous array read)

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). Both are fixed.
- Reset values: state IDLE, buf_valid=0, buf_addr=0, INSTRUCTION=RESET_INSTR, MEM_READ=0, MEM_ADDR=0, FETCH_ERR=0, byte count=0.
- hit = buf_valid & (PC == buf_addr).
- err = PC[1:0]!=0 | PC[31:ADDR_WIDTH]!=0.
- BUSYWAIT = (state!=IDLE) | (FETCH & !hit & !err). BUSYWAIT is combinational; the core samples it before its next edge.
- FSM states: IDLE, READ.
- IDLE:
  - FETCH & err: FETCH_ERR=1 for the next cycle. No memory access. INSTRUCTION unchanged. BUSYWAIT=0. Stay in IDLE.
  - FETCH & hit: no action; INSTRUCTION already valid.
  - FETCH & miss: latch base=PC[ADDR_WIDTH-1:0], cnt=0, MEM_ADDR=base, MEM_READ=1. Go to READ.
- READ:
  - Each edge captures MEM_RDATA into byte lane cnt, increments cnt, and sets MEM_ADDR=base+cnt+1.
  - On the edge capturing lane 3: INSTRUCTION=assembled word, buf_addr=base, buf_valid=1, MEM_READ=0. Go to IDLE.
- Miss latency: request cycle c0, then MEM_READ high c1..c4, BUSYWAIT high c0..c4. INSTRUCTION valid and BUSYWAIT low in c5 if PC is unchanged. Total miss penalty is 5 stall cycles; hit penalty is 0.
- PC changing during READ does not abort the fetch; the latched base completes. Back in IDLE the new PC is compared and misses normally.
- FLUSH:
  - In IDLE: clears buf_valid next edge; INSTRUCTION=RESET_INSTR.
  - In READ: the fetch completes, but buf_valid is forced 0 at completion. INSTRUCTION still updates so the core is not deadlocked if PC==base; the next FETCH refetches.
- FLUSH and a FETCH miss in the same IDLE cycle: flush applies and the fetch starts.
- RESET has priority over everything. RESET mid-READ returns to IDLE, drops MEM_READ next edge, and discards partial bytes.
- MEM_ADDR never wraps within a word: aligned base guarantees base+3 ≤ 2^ADDR_WIDTH-1.
- FETCH_ERR is registered and lasts exactly one cycle per erroneous request cycle.

Decomposition:
- Shared package cpu_fetch_pkg holds:
  - state encoding (IDLE=1'b0, READ=1'b1)
  - BYTES_PER_WORD=4
  - RESET_INSTR default
  - INSTR_W=32
- One sub-module, fetch_byte_assembler: lane-indexed 4x8 capture register with a load-lane input. It outputs the {b3,b2,b1,b0} word and keeps the byte-steering logic out of the FSM.

Test Plan:
- Memory bytes 0..3 = 03,00,00,00; RESET 2 cycles; FETCH=1, PC=0 -> MEM_ADDR 0,1,2,3 in c1..c4; BUSYWAIT high c0..c4; INSTRUCTION=32'h0000_0003 in c5; BUSYWAIT low c5.
- After the previous case, FETCH PC=0 again -> BUSYWAIT=0 in the same cycle, MEM_READ stays 0, INSTRUCTION=32'h0000_0003.
- Bytes 8..11 = 00,01,02,02; FETCH PC=8; PC changed to 12 in c2 -> word 32'h0202_0100 latched for addr 8; the next cycle BUSYWAIT high again and MEM_ADDR=12.
- FETCH PC=6, then PC=32'h400 -> FETCH_ERR pulses one cycle each, MEM_READ=0, BUSYWAIT=0, INSTRUCTION unchanged.
- FLUSH=1 for one IDLE cycle after a hit on PC=0 -> INSTRUCTION=32'h0, the next FETCH PC=0 takes the full 5-cycle miss.
- RESET asserted in c2 of a miss on PC=4 -> MEM_READ=0 after that edge, buf_valid=0, INSTRUCTION=RESET_INSTR; a new fetch of PC=4 returns correct word 32'h0001_0005.
